// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl : hazard, forwarding and memory-wait control for the
// 5-stage pipeline. Optional counters: define HAZARD_PERF_CNT_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs_addr,
  input  logic [4:0] id_rt_addr,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rs_addr,
  input  logic [4:0] ex_rt_addr,
  input  logic       ex_MemRead,
  input  logic       ex_redirect,
  input  logic [4:0] mem_dest,
  input  logic       mem_RegWrite,
  input  logic       mem_access,
  input  logic       mem_ready,
  input  logic [4:0] wb_dest,
  input  logic       wb_RegWrite,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_write,
  output logic       idex_bubble,
  output logic       exmem_write,
  output logic       memwb_bubble,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       halted,
  output logic [1:0] state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
`endif
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] C_TIMEOUT = WCNT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALT     = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  logic mem_wait;
  logic frozen;
  logic load_use;
  logic do_redirect;
  logic do_stall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (mem_RegWrite && (mem_dest != 5'd0) && (mem_dest == src))
      return 2'b10;
    else if (wb_RegWrite && (wb_dest != 5'd0) && (wb_dest == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    mem_wait = ((state_q == ST_RUN) && mem_access && !mem_ready) ||
               ((state_q == ST_MEM_WAIT) && !mem_ready);
    frozen   = (state_q == ST_HALT) || mem_wait;
    load_use = ex_MemRead && (ex_rt_addr != 5'd0) &&
               ((ex_rt_addr == id_rs_addr) || (id_uses_rt && (ex_rt_addr == id_rt_addr)));
    do_redirect = !reset && !frozen && ex_redirect;
    do_stall    = !reset && !frozen && !ex_redirect && load_use;
  end

  // Pipeline control outputs; reset overrides everything, then the priority chain.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b1;
    memwb_bubble = 1'b0;
    halted       = 1'b0;
    fwd_a        = 2'b00;
    fwd_b        = 2'b00;
    if (reset) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end else begin
      fwd_a = fwd_sel(ex_rs_addr);
      fwd_b = fwd_sel(ex_rt_addr);
      if (frozen) begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b1;
        halted       = (state_q == ST_HALT);
      end else if (ex_redirect) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  assign state = state_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_access && !mem_ready) begin
          state_d = ST_MEM_WAIT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_d = ST_RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == C_TIMEOUT) begin
          state_d = ST_HALT;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: begin
        state_d = ST_RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (do_stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (do_redirect && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    if (frozen && (wait_cnt_q != '1))
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign wait_cnt  = wait_cnt_q;
`else
  logic unused_events;
  assign unused_events = do_stall ^ do_redirect;

  // Counter width only matters when the counters are built.
  if (CNT_W < 1) begin : g_no_perf_cnt
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// tb_pipeline_hazard_ctrl : directed and random checks of pipeline_hazard_ctrl
// against a cycle-level reference model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs_addr, id_rt_addr, ex_rs_addr, ex_rt_addr, mem_dest, wb_dest;
  logic       id_uses_rt, ex_MemRead, ex_redirect, mem_RegWrite, mem_access, mem_ready, wb_RegWrite;
  logic       pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble;
  logic [1:0] fwd_a, fwd_b, state;
  logic       halted;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, wait_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: 0 running, 1 waiting on memory, 2 halted.
  int m_state = 0;
  int m_waits = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_uses_rt(id_uses_rt),
    .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_MemRead(ex_MemRead),
    .ex_redirect(ex_redirect), .mem_dest(mem_dest), .mem_RegWrite(mem_RegWrite),
    .mem_access(mem_access), .mem_ready(mem_ready), .wb_dest(wb_dest),
    .wb_RegWrite(wb_RegWrite), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_write(idex_write), .idex_bubble(idex_bubble),
    .exmem_write(exmem_write), .memwb_bubble(memwb_bubble), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .halted(halted), .state(state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (mem_RegWrite && mem_dest != 0 && mem_dest == src) return 2'b10;
    if (wb_RegWrite && wb_dest != 0 && wb_dest == src) return 2'b01;
    return 2'b00;
  endfunction

  // Check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic cycle(input string tag);
    logic [7:0] e_ctrl;
    logic [1:0] e_fa, e_fb;
    bit waiting, lu;
    @(negedge clk);
    waiting = (m_state == 0 && mem_access && !mem_ready) || (m_state == 1 && !mem_ready);
    lu = ex_MemRead && ex_rt_addr != 0 &&
         (ex_rt_addr == id_rs_addr || (id_uses_rt && ex_rt_addr == id_rt_addr));
    // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble, halted}
    e_fa = exp_fwd(ex_rs_addr);
    e_fb = exp_fwd(ex_rt_addr);
    if (reset) begin
      e_ctrl = 8'b0011_1110;
      e_fa = 2'b00;
      e_fb = 2'b00;
    end else if (m_state == 2) e_ctrl = 8'b0000_0011;
    else if (waiting)        e_ctrl = 8'b0000_0010;
    else if (ex_redirect)    e_ctrl = 8'b1111_1100;
    else if (lu)             e_ctrl = 8'b0001_1100;
    else                     e_ctrl = 8'b1101_0100;
    chk({tag, ".ctrl"}, {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
                         exmem_write, memwb_bubble, halted}, e_ctrl);
    chk({tag, ".fwd"}, {4'b0, fwd_a, fwd_b}, {4'b0, e_fa, e_fb});
    chk({tag, ".state"}, {6'b0, state}, 8'(m_state));
    @(posedge clk);
    if (reset) begin
      m_state = 0;
      m_waits = 0;
    end else if (m_state != 2) begin
      if (waiting) begin
        m_waits++;
        m_state = (m_waits > TIMEOUT) ? 2 : 1;
      end else begin
        m_state = 0;
        m_waits = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    id_rs_addr = 0; id_rt_addr = 0; id_uses_rt = 0;
    ex_rs_addr = 0; ex_rt_addr = 0; ex_MemRead = 0; ex_redirect = 0;
    mem_dest = 0; mem_RegWrite = 0; mem_access = 0; mem_ready = 1;
    wb_dest = 0; wb_RegWrite = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    @(posedge clk); #1;
    cycle("reset0");
    cycle("reset1");
    reset = 0;
    cycle("idle");

    ex_MemRead = 1; ex_rt_addr = 9; id_rs_addr = 9;
    cycle("load_use");
    ex_MemRead = 0;
    cycle("after_load_use");

    ex_MemRead = 1; ex_redirect = 1;
    cycle("redirect_wins");
    idle();

    mem_access = 1; mem_ready = 0;
    repeat (3) cycle("mem_wait");
    mem_ready = 1;
    cycle("mem_ready");
    mem_access = 0;
    cycle("mem_resume");

    mem_access = 1; mem_ready = 0;
    repeat (7) cycle("timeout");
    mem_access = 0; mem_ready = 1; ex_redirect = 1;
    cycle("halt_hold");
    ex_redirect = 0; reset = 1;
    cycle("halt_reset");
    reset = 0;
    cycle("after_halt");

    mem_dest = 5; wb_dest = 5; mem_RegWrite = 1; wb_RegWrite = 1;
    ex_rs_addr = 5; ex_rt_addr = 0;
    cycle("fwd_mem");
    mem_RegWrite = 0;
    cycle("fwd_wb");
    idle();

    for (int i = 0; i < 800; i++) begin
      reset        = ($urandom_range(0, 49) == 0);
      id_rs_addr   = 5'($urandom_range(0, 3));
      id_rt_addr   = 5'($urandom_range(0, 3));
      id_uses_rt   = 1'($urandom);
      ex_rs_addr   = 5'($urandom_range(0, 3));
      ex_rt_addr   = 5'($urandom_range(0, 3));
      ex_MemRead   = 1'($urandom);
      ex_redirect  = ($urandom_range(0, 3) == 0);
      mem_dest     = 5'($urandom_range(0, 3));
      mem_RegWrite = 1'($urandom);
      wb_dest      = 5'($urandom_range(0, 3));
      wb_RegWrite  = 1'($urandom);
      mem_access   = ($urandom_range(0, 3) == 0);
      mem_ready    = ($urandom_range(0, 9) < 6);
      // The cycle memory completes is kept free of redirect and load-use.
      if (m_state == 1 && mem_ready) begin
        ex_redirect = 0;
        ex_MemRead  = 0;
      end
      cycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
